// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding and constants for the UART frame arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FIN
  } arb_state_e;

  localparam int         ARB_ACK_TIMEOUT = 15;
  localparam logic [7:0] ARB_HDR_DEFAULT = 8'h22;
  localparam logic [7:0] ARB_TRL_DEFAULT = 8'h55;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int arb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// rtl/uart_frame_arbiter_if.sv - requester and UART TX signal bundle for the frame arbiter
interface uart_frame_arbiter_if #(
  parameter int NREQ    = 2,
  parameter int MAX_LEN = 4
) ();

  logic [NREQ-1:0]           req;
  logic [NREQ*4-1:0]         req_len;
  logic [NREQ*MAX_LEN*8-1:0] req_data;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           done;
  logic                      busy;
  logic [7:0]                tx_data;
  logic                      tx_start;
  logic                      tx_busy;

  // Requesters plus the UART transmitter sit on the master side.
  modport master (
    output req, req_len, req_data, tx_busy,
    input  grant, done, busy, tx_data, tx_start
  );

  modport slave (
    input  req, req_len, req_data, tx_busy,
    output grant, done, busy, tx_data, tx_start
  );

endinterface

// File: rtl/uart_arb_pick.sv
// rtl/uart_arb_pick.sv - combinational winner selection; UART_ARB_RR_EN selects round-robin,
// otherwise fixed priority with the lowest index winning.
module uart_arb_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = arb_idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifdef UART_ARB_RR_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

`ifdef UART_ARB_RR_EN
  logic [IW-1:0] cand;

  // Search begins one past the last winner and wraps, so the last winner is tried last.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end
`else
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[k]) begin
        valid     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - shares one UART TX among requesters, framing each grant as
// HDR, payload, HDR, TRL; UART_ARB_RR_EN enables round-robin arbitration.
module uart_frame_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NREQ    = 2,
  parameter int         MAX_LEN = 4,
  parameter logic [7:0] HDR     = ARB_HDR_DEFAULT,
  parameter logic [7:0] TRL     = ARB_TRL_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  uart_frame_arbiter_if.slave bus
);

  localparam int IW   = arb_idx_width(NREQ);
  localparam int IDXW = $clog2(MAX_LEN + 3);
  localparam int PW   = MAX_LEN * 8;

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] len_q, len_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [3:0]      ack_cnt_q, ack_cnt_d;
  logic            ack_err_q, ack_err_d;

  logic            pick_valid;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic [3:0]      sel_len;
  logic [PW-1:0]   sel_data;
  logic [IDXW-1:0] sel_len_clamped;

`ifdef UART_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
`endif

  uart_arb_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (bus.req),
`ifdef UART_ARB_RR_EN
    .ptr    (ptr_q),
`endif
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign sel_len         = bus.req_len[int'(pick_idx)*4 +: 4];
  assign sel_data        = bus.req_data[int'(pick_idx)*PW +: PW];
  assign sel_len_clamped = (sel_len > 4'(MAX_LEN)) ? IDXW'(MAX_LEN) : IDXW'(sel_len);

  // Frame position i maps to HDR, payload[0..n-1], HDR, TRL.
  function automatic logic [7:0] frame_byte(input logic [IDXW-1:0] i,
                                            input logic [IDXW-1:0] n,
                                            input logic [PW-1:0]   pl);
    logic [7:0] b;
    if (i == '0)                  b = HDR;
    else if (i <= n)              b = pl[8*(int'(i)-1) +: 8];
    else if (i == n + IDXW'(1))   b = HDR;
    else                          b = TRL;
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pay_d      = pay_q;
    grant_d    = grant_q;
    done_d     = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ack_cnt_d  = ack_cnt_q;
    ack_err_d  = ack_err_q;
`ifdef UART_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && !bus.tx_busy) begin
          state_d    = ST_START;
          grant_d    = pick_onehot;
          len_d      = sel_len_clamped;
          pay_d      = sel_data;
          idx_d      = '0;
          tx_start_d = 1'b1;
          tx_data_d  = HDR;
`ifdef UART_ARB_RR_EN
          ptr_d      = pick_idx;
`endif
        end
      end
      ST_START: begin
        state_d   = ST_WAIT_ACK;
        ack_cnt_d = '0;
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == 4'(ARB_ACK_TIMEOUT - 1)) begin
          // UART never acknowledged: flag it and keep the frame moving.
          ack_err_d = 1'b1;
          state_d   = ST_WAIT_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (idx_q == len_q + IDXW'(2)) begin
            state_d = ST_FIN;
            done_d  = grant_q;
          end else begin
            state_d    = ST_START;
            idx_d      = idx_q + IDXW'(1);
            tx_start_d = 1'b1;
            tx_data_d  = frame_byte(idx_q + IDXW'(1), len_q, pay_q);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      pay_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_cnt_q  <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      pay_q      <= pay_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_cnt_q  <= ack_cnt_d;
      ack_err_q  <= ack_err_d;
    end
  end

`ifdef UART_ARB_RR_EN
  // Pointer starts at the top index so the first search begins at requester 0.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(NREQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule
